idct_mac_unit: RTL and testbench

//  Decoder-side counterpart of the fdct_zigzag DCT MAC unit.
//  - Accumulates TAPS products of (dequantised DCT coefficient x cosine constant).
//  - Rounds, scales, level-shifts by +128 and emits one 8-bit pixel per block of TAPS taps.
//  - Sits in the IDCT block of the jpeg decoder, between the coefficient/cosine sequencer and the row/column transpose buffer.

---
 rtl/idct_mac_unit.sv | 146 ++++++++++++++
 tb/tb_idct_mac_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_mac_unit.sv
// Pipelined IDCT multiply-accumulate: sums TAPS coefficient x cosine products, rounds, shifts
// and level-shifts to one 8-bit pixel per block. Optional clamping via IDCT_MAC_SAT_EN.
module idct_mac_unit #(
    parameter int unsigned DIN_W  = 12,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned ACC_W  = 27,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned SHIFT  = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DIN_W-1:0]  in_coef,
    input  logic signed [COEF_W-1:0] in_cos,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_pix,
    output logic                     out_clip
);

    localparam int unsigned PROD_W = DIN_W + COEF_W;
    localparam int unsigned CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LastTap = CNT_W'(TAPS - 1);
    localparam logic [ACC_W-1:0] RoundBias = ACC_W'(1) << (SHIFT - 1);

    logic                     stall;
    logic                     xfer;
    logic                     s2_fire;

    logic [CNT_W-1:0]         tap_cnt_q, tap_cnt_d;
    logic signed [PROD_W-1:0] p_q, p_d;
    logic                     p_valid_q, p_valid_d;
    logic                     p_last_q, p_last_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic [7:0]               out_pix_q, out_pix_d;
    logic                     out_clip_q, out_clip_d;

    logic signed [ACC_W-1:0]  p_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  sum_rnd;
    logic signed [ACC_W-1:0]  sum_sh;
    logic signed [ACC_W:0]    v;
    logic [7:0]               pix;
    logic                     clip;

    // Rounding datapath for the final tap of a block.
    always_comb begin
        p_ext   = ACC_W'(p_q);
        sum     = acc_q + p_ext;
        sum_rnd = sum + $signed(RoundBias);
        sum_sh  = sum_rnd >>> SHIFT;
        v       = {sum_sh[ACC_W-1], sum_sh} + (ACC_W + 1)'(128);
    end

`ifdef IDCT_MAC_SAT_EN
    always_comb begin
        pix  = v[7:0];
        clip = 1'b0;
        if (v < 0) begin
            pix  = 8'd0;
            clip = 1'b1;
        end else if (v > 255) begin
            pix  = 8'd255;
            clip = 1'b1;
        end
    end
`else
    logic unused_v_hi;
    assign unused_v_hi = ^v[ACC_W:8];

    always_comb begin
        pix  = v[7:0];
        clip = 1'b0;
    end
`endif

    always_comb begin
        stall    = out_valid_q & ~out_ready;
        in_ready = ~stall;
        xfer     = in_valid & ~stall;
        s2_fire  = p_valid_q & ~stall;

        tap_cnt_d   = tap_cnt_q;
        p_d         = p_q;
        p_valid_d   = p_valid_q;
        p_last_d    = p_last_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        out_clip_d  = out_clip_q;

        if (xfer) begin
            p_d       = in_coef * in_cos;
            p_last_d  = (tap_cnt_q == LastTap);
            tap_cnt_d = (tap_cnt_q == LastTap) ? '0 : tap_cnt_q + CNT_W'(1);
        end
        // Whole pipeline freezes under stall, so p_valid only tracks transfers otherwise.
        if (!stall) begin
            p_valid_d = xfer;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (s2_fire) begin
            if (p_last_q) begin
                acc_d       = '0;
                out_valid_d = 1'b1;
                out_pix_d   = pix;
                out_clip_d  = clip;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt_q   <= '0;
            p_q         <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= 8'd0;
            out_clip_q  <= 1'b0;
        end else begin
            tap_cnt_q   <= tap_cnt_d;
            p_q         <= p_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_clip_q  <= out_clip_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_clip  = out_clip_q;

endmodule

// File: tb/tb_idct_mac_unit.sv
// Directed bench for idct_mac_unit: fixed blocks, back-pressure, mid-block reset and a
// randomised in-order stream against a behavioural model. Honours IDCT_MAC_SAT_EN.
module tb_idct_mac_unit;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [11:0] in_coef;
    logic signed [11:0] in_cos;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_pix;
    logic              out_clip;

    int checks = 0;
    int errors = 0;

    idct_mac_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .in_cos    (in_cos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_clip  (out_clip)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Feeds n taps, waiting (bounded) for in_ready; ends at a negedge with in_valid low.
    task automatic feed_taps(input int n, input int c, input int k);
        int guard;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_coef  = 12'(c);
            in_cos   = 12'(k);
            #1;
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard == 100) check("feed_timeout", 64'(in_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic do_block(input string tag, input int c, input int k,
                            input int exp_pix, input int exp_clip);
        int lat;
        feed_taps(8, c, k);
        wait_result(tag, lat);
        check({tag, "_pix"}, 64'(out_pix), 64'(exp_pix));
        check({tag, "_clip"}, 64'(out_clip), 64'(exp_clip));
        @(negedge clk);
    endtask

    function automatic int model(input longint s);
        longint r;
        longint v;
        r = (s + 64'sd4096) >>> 13;
        v = r + 128;
`ifdef IDCT_MAC_SAT_EN
        if (v < 0) return 256;
        if (v > 255) return 256 + 255;
        return int'(v);
`else
        return int'(v & 255);
`endif
    endfunction

    int lat;
    int hits;
    int t_first;
    int t_second;
    int p_first;
    int p_second;
    int exp_q[$];
    int exp_v;
    int blocks_in;
    int blocks_out;
    int tap_i;
    int cyc;
    int cur_c;
    int cur_k;
    longint accum;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_coef   = '0;
        in_cos    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pix", 64'(out_pix), 64'd0);
        check("rst_out_clip", 64'(out_clip), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // T1 with latency: result loads on the edge after the one taking tap 8.
        feed_taps(8, 64, 1024);
        check("t1_early_valid", 64'(out_valid), 64'd0);
        wait_result("t1", lat);
        check("t1_latency", 64'(lat), 64'd1);
        check("t1_pix", 64'(out_pix), 64'd192);
        check("t1_clip", 64'(out_clip), 64'd0);
        @(negedge clk);
        check("t1_drop_valid", 64'(out_valid), 64'd0);

        // T2
        do_block("t2_zero", 0, 1024, 128, 0);
        do_block("t2_neg", -64, 1024, 64, 0);

        // T3
`ifdef IDCT_MAC_SAT_EN
        do_block("t3_pos", 2047, 2047, 255, 1);
        do_block("t3_neg", -2047, 2047, 0, 1);
`else
        do_block("t3_pos", 2047, 2047, 124, 0);
        do_block("t3_neg", -2047, 2047, 132, 0);
`endif

        // Back-to-back blocks with out_ready high: results exactly TAPS cycles apart.
        hits = 0; t_first = -1; t_second = -1; p_first = -1; p_second = -1;
        for (int i = 0; i < 22; i++) begin
            in_valid = (i < 16);
            in_coef  = (i < 8) ? 12'sd64 : -12'sd64;
            in_cos   = 12'sd1024;
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                if (hits == 0) begin t_first = i; p_first = out_pix; end
                else if (hits == 1) begin t_second = i; p_second = out_pix; end
                hits++;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 64'(hits), 64'd2);
        check("b2b_gap", 64'(t_second - t_first), 64'd8);
        check("b2b_pix0", 64'(p_first), 64'd192);
        check("b2b_pix1", 64'(p_second), 64'd64);

        // T4: hold the result and stall the input side.
        out_ready = 1'b0;
        feed_taps(8, 64, 1024);
        wait_result("t4_first", lat);
        check("t4_first_pix", 64'(out_pix), 64'd192);
        in_valid = 1'b1;
        in_coef  = 12'sd64;
        in_cos   = 12'sd1024;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_stall_in_ready", 64'(in_ready), 64'd0);
            check("t4_stall_pix", 64'(out_pix), 64'd192);
            check("t4_stall_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("t4_release_in_ready", 64'(in_ready), 64'd1);
        feed_taps(8, 64, 1024);
        wait_result("t4_next", lat);
        check("t4_next_pix", 64'(out_pix), 64'd192);
        @(negedge clk);

        // T5: reset mid-block discards the partial sum.
        feed_taps(3, 100, 1024);
        rst_n = 1'b0;
        #2;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_no_stale", 64'(out_valid), 64'd0);
        do_block("t5", 64, 1024, 192, 0);

        // T6: random gaps and back-pressure against the model.
        blocks_in = 0; blocks_out = 0; tap_i = 0; cyc = 0; accum = 0;
        cur_c = int'($urandom_range(0, 4095)) - 2048;
        cur_k = int'($urandom_range(0, 4095)) - 2048;
        while (blocks_out < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = (blocks_in < 1000) && ($urandom_range(0, 9) < 7);
            in_coef   = 12'(cur_c);
            in_cos    = 12'(cur_k);
            #1;
            if (out_valid && out_ready) begin
                check("t6_queue", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check("t6_pix", 64'(out_pix), 64'(exp_v & 255));
                    check("t6_clip", 64'(out_clip), 64'((exp_v >> 8) & 1));
                end
                blocks_out++;
            end
            if (in_valid && in_ready) begin
                accum += longint'(cur_c) * longint'(cur_k);
                tap_i++;
                if (tap_i == 8) begin
                    exp_q.push_back(model(accum));
                    accum = 0;
                    tap_i = 0;
                    blocks_in++;
                end
                cur_c = int'($urandom_range(0, 4095)) - 2048;
                cur_k = int'($urandom_range(0, 4095)) - 2048;
            end
        end
        in_valid = 1'b0;
        check("t6_blocks", 64'(blocks_out), 64'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
